// File: rtl/pu_check_arbiter.sv
// Round-robin arbiter sharing one policy checker between the AXI AR and AW request channels.
// Optional deny counters are compiled in with `define PU_CHECK_DENY_STATS_EN.
module pu_check_arbiter #(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic                  AR_VALID,
    output logic                  AR_READY,
    input  logic [ID_WIDTH-1:0]   AR_ID,
    input  logic [ADDR_WIDTH-1:0] AR_ADDR,
    input  logic [7:0]            AR_LEN,
    input  logic [2:0]            AR_SIZE,

    input  logic                  AW_VALID,
    output logic                  AW_READY,
    input  logic [ID_WIDTH-1:0]   AW_ID,
    input  logic [ADDR_WIDTH-1:0] AW_ADDR,
    input  logic [7:0]            AW_LEN,
    input  logic [2:0]            AW_SIZE,

    output logic [ID_WIDTH-1:0]   CHK_ID,
    output logic [ADDR_WIDTH-1:0] CHK_ADDR,
    output logic [7:0]            CHK_LEN,
    output logic [2:0]            CHK_SIZE,
    output logic                  CHK_READ_WRITE,
    input  logic                  CHK_GRANTED,

    output logic                  AR_RES_VALID,
    input  logic                  AR_RES_READY,
    output logic                  AR_RES_GRANTED,

    output logic                  AW_RES_VALID,
    input  logic                  AW_RES_READY,
    output logic                  AW_RES_GRANTED,

`ifdef PU_CHECK_DENY_STATS_EN
    output logic [STAT_WIDTH-1:0] DENY_CNT_R,
    output logic [STAT_WIDTH-1:0] DENY_CNT_W,
`endif
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising ACLK edge where VALID and READY
    // are both 1. VALID may drop before READY without effect; the request READYs
    // are combinational from VALID, the result VALID/GRANTED pair is registered
    // and held stable until its READY completes the transfer.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state_q;
    logic   wr_turn_q;
    logic   pick_write;
    logic   accept;
    logic   res_done;

    if (STAT_WIDTH < 1) begin : g_bad_stat_width
        $error("STAT_WIDTH must be at least 1");
    end

    assign dbg_state = state_q;

    // wr_turn_q set means the read was served last, so a tied contest goes to the write.
    assign pick_write = AW_VALID && (!AR_VALID || wr_turn_q);
    assign AR_READY   = ARESETN && (state_q == S_IDLE) && AR_VALID && !pick_write;
    assign AW_READY   = ARESETN && (state_q == S_IDLE) && pick_write;
    assign accept     = AR_READY || AW_READY;
    assign res_done   = (AR_RES_VALID && AR_RES_READY) || (AW_RES_VALID && AW_RES_READY);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q        <= S_IDLE;
            wr_turn_q      <= 1'b0;
            CHK_ID         <= '0;
            CHK_ADDR       <= '0;
            CHK_LEN        <= '0;
            CHK_SIZE       <= '0;
            CHK_READ_WRITE <= 1'b0;
            AR_RES_VALID   <= 1'b0;
            AR_RES_GRANTED <= 1'b0;
            AW_RES_VALID   <= 1'b0;
            AW_RES_GRANTED <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        CHK_ID         <= pick_write ? AW_ID   : AR_ID;
                        CHK_ADDR       <= pick_write ? AW_ADDR : AR_ADDR;
                        CHK_LEN        <= pick_write ? AW_LEN  : AR_LEN;
                        CHK_SIZE       <= pick_write ? AW_SIZE : AR_SIZE;
                        CHK_READ_WRITE <= pick_write;
                        wr_turn_q      <= !pick_write;
                        state_q        <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    AR_RES_VALID   <= !CHK_READ_WRITE;
                    AR_RES_GRANTED <= !CHK_READ_WRITE && CHK_GRANTED;
                    AW_RES_VALID   <= CHK_READ_WRITE;
                    AW_RES_GRANTED <= CHK_READ_WRITE && CHK_GRANTED;
                    state_q        <= S_RESP;
                end
                S_RESP: begin
                    if (res_done) begin
                        AR_RES_VALID   <= 1'b0;
                        AR_RES_GRANTED <= 1'b0;
                        AW_RES_VALID   <= 1'b0;
                        AW_RES_GRANTED <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PU_CHECK_DENY_STATS_EN
    // Saturating counters; the checker verdict is sampled on the CHECK->RESP edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            DENY_CNT_R <= '0;
            DENY_CNT_W <= '0;
        end else if (state_q == S_CHECK && !CHK_GRANTED) begin
            if (CHK_READ_WRITE) begin
                if (DENY_CNT_W != '1) DENY_CNT_W <= DENY_CNT_W + STAT_WIDTH'(1);
            end else begin
                if (DENY_CNT_R != '1) DENY_CNT_R <= DENY_CNT_R + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pu_check_arbiter.sv
// Bench for pu_check_arbiter: directed scenarios plus random traffic, all checked against
// a transaction-level model; the deny-counter checks compile with PU_CHECK_DENY_STATS_EN.
module tb_pu_check_arbiter;

  localparam int SW      = 2;
  localparam int SAT_MAX = (1 << SW) - 1;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        AR_VALID, AR_READY, AW_VALID, AW_READY;
  logic [15:0] AR_ID, AW_ID, CHK_ID;
  logic [31:0] AR_ADDR, AW_ADDR, CHK_ADDR;
  logic [7:0]  AR_LEN, AW_LEN, CHK_LEN;
  logic [2:0]  AR_SIZE, AW_SIZE, CHK_SIZE;
  logic        CHK_READ_WRITE, CHK_GRANTED;
  logic        AR_RES_VALID, AR_RES_READY, AR_RES_GRANTED;
  logic        AW_RES_VALID, AW_RES_READY, AW_RES_GRANTED;
  logic [SW-1:0] DENY_CNT_R, DENY_CNT_W;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  pu_check_arbiter #(.ID_WIDTH(16), .ADDR_WIDTH(32), .STAT_WIDTH(SW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ID(AR_ID), .AR_ADDR(AR_ADDR),
    .AR_LEN(AR_LEN), .AR_SIZE(AR_SIZE),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ID(AW_ID), .AW_ADDR(AW_ADDR),
    .AW_LEN(AW_LEN), .AW_SIZE(AW_SIZE),
    .CHK_ID(CHK_ID), .CHK_ADDR(CHK_ADDR), .CHK_LEN(CHK_LEN), .CHK_SIZE(CHK_SIZE),
    .CHK_READ_WRITE(CHK_READ_WRITE), .CHK_GRANTED(CHK_GRANTED),
    .AR_RES_VALID(AR_RES_VALID), .AR_RES_READY(AR_RES_READY), .AR_RES_GRANTED(AR_RES_GRANTED),
    .AW_RES_VALID(AW_RES_VALID), .AW_RES_READY(AW_RES_READY), .AW_RES_GRANTED(AW_RES_GRANTED),
`ifdef PU_CHECK_DENY_STATS_EN
    .DENY_CNT_R(DENY_CNT_R), .DENY_CNT_W(DENY_CNT_W),
`endif
    .dbg_state(dbg_state)
  );

`ifndef PU_CHECK_DENY_STATS_EN
  assign DENY_CNT_R = '0;
  assign DENY_CNT_W = '0;
`endif

  // ---------------- clock ----------------
  always #5 ACLK = ~ACLK;

  // Checker policy: region 0xF denies everything, region 0xE denies writes.
  function automatic logic policy(input logic [31:0] a, input logic rw);
    return !((a[15:12] == 4'hF) || (rw && a[15:12] == 4'hE));
  endfunction

  assign CHK_GRANTED = policy(CHK_ADDR, CHK_READ_WRITE);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy;
  int          m_age;        // cycles since acceptance while busy
  bit          m_last_w;     // direction served last; 1 after reset so reads go first
  bit          m_verdict;
  logic [15:0] m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  bit          m_rw;
  int          m_den_r, m_den_w;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      check("rst_ar_ready", AR_READY, 0);
      check("rst_aw_ready", AW_READY, 0);
      check("rst_ar_res_valid", AR_RES_VALID, 0);
      check("rst_aw_res_valid", AW_RES_VALID, 0);
      check("rst_ar_res_granted", AR_RES_GRANTED, 0);
      check("rst_aw_res_granted", AW_RES_GRANTED, 0);
      check("rst_chk_addr", CHK_ADDR, 0);
      check("rst_chk_id", CHK_ID, 0);
      m_busy = 0; m_age = 0; m_last_w = 1; m_verdict = 0;
      m_id = '0; m_addr = '0; m_len = '0; m_size = '0; m_rw = 0;
      m_den_r = 0; m_den_w = 0;
`ifdef PU_CHECK_DENY_STATS_EN
      check("rst_deny_r", DENY_CNT_R, 0);
      check("rst_deny_w", DENY_CNT_W, 0);
`endif
    end else begin
      bit exp_w, exp_ar_rdy, exp_aw_rdy, exp_resp;
      exp_w      = AW_VALID && (!AR_VALID || !m_last_w);
      exp_ar_rdy = !m_busy && AR_VALID && !exp_w;
      exp_aw_rdy = !m_busy && exp_w;
      exp_resp   = m_busy && (m_age >= 2);
      check("ar_ready", AR_READY, exp_ar_rdy);
      check("aw_ready", AW_READY, exp_aw_rdy);
      check("chk_id", CHK_ID, m_id);
      check("chk_addr", CHK_ADDR, m_addr);
      check("chk_len", CHK_LEN, m_len);
      check("chk_size", CHK_SIZE, m_size);
      check("chk_rw", CHK_READ_WRITE, m_rw);
      check("ar_res_valid", AR_RES_VALID, exp_resp && !m_rw);
      check("aw_res_valid", AW_RES_VALID, exp_resp && m_rw);
      if (exp_resp)
        check("res_granted", m_rw ? AW_RES_GRANTED : AR_RES_GRANTED, m_verdict);
`ifdef PU_CHECK_DENY_STATS_EN
      check("deny_r", DENY_CNT_R, m_den_r);
      check("deny_w", DENY_CNT_W, m_den_w);
`endif
      // advance to the state after the coming edge
      if (!m_busy) begin
        if (exp_ar_rdy || exp_aw_rdy) begin
          m_rw   = exp_w;
          m_id   = exp_w ? AW_ID : AR_ID;
          m_addr = exp_w ? AW_ADDR : AR_ADDR;
          m_len  = exp_w ? AW_LEN : AR_LEN;
          m_size = exp_w ? AW_SIZE : AR_SIZE;
          m_last_w = exp_w;
          m_busy = 1;
          m_age  = 1;
        end
      end else if (m_age == 1) begin
        m_verdict = policy(m_addr, m_rw);
        if (!m_verdict) begin
          if (m_rw) m_den_w = (m_den_w < SAT_MAX) ? m_den_w + 1 : m_den_w;
          else      m_den_r = (m_den_r < SAT_MAX) ? m_den_r + 1 : m_den_r;
        end
        m_age = 2;
      end else if (m_rw ? AW_RES_READY : AR_RES_READY) begin
        m_busy = 0;
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic do_reset();
    ARESETN = 1'b0;
    AR_VALID = 1'b0; AW_VALID = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
  endtask

  task automatic send(input bit rw, input logic [15:0] id, input logic [31:0] addr,
                      input logic [7:0] len, input logic [2:0] size);
    bit acc = 0;
    if (rw) begin AW_ID = id; AW_ADDR = addr; AW_LEN = len; AW_SIZE = size; AW_VALID = 1'b1; end
    else    begin AR_ID = id; AR_ADDR = addr; AR_LEN = len; AR_SIZE = size; AR_VALID = 1'b1; end
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge ACLK); #1;
      if (rw ? AW_READY : AR_READY) acc = 1;
      @(posedge ACLK); #1;
    end
    if (rw) AW_VALID = 1'b0; else AR_VALID = 1'b0;
    check("accept_seen", acc, 1);
  endtask

  task automatic wait_resp(input bit rw, output logic g);
    bit seen = 0;
    g = 1'bx;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge ACLK); #1;
      if (rw ? AW_RES_VALID : AR_RES_VALID) begin
        seen = 1;
        g = rw ? AW_RES_GRANTED : AR_RES_GRANTED;
      end
      @(posedge ACLK); #1;
    end
    check("resp_seen", seen, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic g;
    int acc_cyc[$];
    bit acc_dir[$];
    int exp_cyc[4];
    bit exp_dir[4];
    int sat_exp[5];

    ARESETN = 1'b0;
    AR_VALID = 1'b1; AW_VALID = 1'b1;   // READYs must stay low under reset regardless
    AR_ID = '0; AR_ADDR = '0; AR_LEN = '0; AR_SIZE = '0;
    AW_ID = '0; AW_ADDR = '0; AW_LEN = '0; AW_SIZE = '0;
    AR_RES_READY = 1'b1; AW_RES_READY = 1'b1;
    #3;
    check("init_ar_ready", AR_READY, 0);
    check("init_chk_addr", CHK_ADDR, 0);
    @(posedge ACLK); #1;
    do_reset();

    // single granted read, cycle-by-cycle
    AR_ID = 16'h0011; AR_ADDR = 32'h0000_1000; AR_LEN = 8'd3; AR_SIZE = 3'd2; AR_VALID = 1'b1;
    @(negedge ACLK); #1;
    check("t1_ar_ready", AR_READY, 1);
    check("t1_aw_ready", AW_READY, 0);
    @(posedge ACLK); #1; AR_VALID = 1'b0;
    @(negedge ACLK); #1;
    check("t1_chk_addr", CHK_ADDR, 32'h0000_1000);
    check("t1_chk_rw", CHK_READ_WRITE, 0);
    check("t1_no_res_yet", AR_RES_VALID, 0);
    @(posedge ACLK); #1;
    @(negedge ACLK); #1;
    check("t1_ar_res_valid", AR_RES_VALID, 1);
    check("t1_ar_res_granted", AR_RES_GRANTED, 1);
    check("t1_aw_res_valid", AW_RES_VALID, 0);
    @(posedge ACLK); #1;

    // both channels held valid: alternate R, W, R, W, three cycles apart
    do_reset();
    exp_cyc = '{0, 3, 6, 9};
    exp_dir = '{0, 1, 0, 1};
    AR_ADDR = 32'h0000_2000; AW_ADDR = 32'h0000_3000;
    AR_VALID = 1'b1; AW_VALID = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge ACLK); #1;
      if (AR_READY) begin acc_cyc.push_back(c); acc_dir.push_back(0); end
      if (AW_READY) begin acc_cyc.push_back(c); acc_dir.push_back(1); end
      @(posedge ACLK); #1;
    end
    AR_VALID = 1'b0; AW_VALID = 1'b0;
    check("t2_accept_count", acc_cyc.size(), 4);
    for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
      check("t2_accept_cycle", acc_cyc[i], exp_cyc[i]);
      check("t2_accept_dir", acc_dir[i], exp_dir[i]);
    end

    // denied write
    send(1, 16'h0022, 32'h0000_F000, 8'd0, 3'd3);
    wait_resp(1, g);
    check("t3_aw_granted", g, 0);
`ifdef PU_CHECK_DENY_STATS_EN
    check("t3_deny_w", DENY_CNT_W, 1);
    check("t3_deny_r", DENY_CNT_R, 0);
`endif

    // read verdict back-pressured for 5 cycles with a write waiting
    AR_RES_READY = 1'b0;
    AR_ADDR = 32'h0000_4000; AW_ADDR = 32'h0000_5000;
    AR_VALID = 1'b1; AW_VALID = 1'b1;
    @(negedge ACLK); #1;
    check("t4_ar_first", AR_READY, 1);
    @(posedge ACLK); #1; AR_VALID = 1'b0;
    @(posedge ACLK); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK); #1;
      check("t4_hold_valid", AR_RES_VALID, 1);
      check("t4_hold_granted", AR_RES_GRANTED, 1);
      check("t4_aw_blocked", AW_READY, 0);
      @(posedge ACLK); #1;
    end
    AR_RES_READY = 1'b1;
    @(negedge ACLK); #1;
    check("t4_aw_blocked_hs", AW_READY, 0);
    @(posedge ACLK); #1;
    @(negedge ACLK); #1;
    check("t4_aw_accepted", AW_READY, 1);
    @(posedge ACLK); #1; AW_VALID = 1'b0;
    wait_resp(1, g);
    check("t4_aw_granted", g, 1);

    // reset during CHECK
    send(0, 16'h0033, 32'h0000_6000, 8'd1, 3'd1);
    #2 ARESETN = 1'b0;
    #1;
    check("t5_chk_addr_cleared", CHK_ADDR, 0);
    check("t5_ar_ready", AR_READY, 0);
    check("t5_ar_res_valid", AR_RES_VALID, 0);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ACLK); #1;
      check("t5_no_res_valid", AR_RES_VALID, 0);
      @(posedge ACLK); #1;
    end
    send(1, 16'h0044, 32'h0000_7000, 8'd2, 3'd2);
    wait_resp(1, g);
    check("t5_next_granted", g, 1);

`ifdef PU_CHECK_DENY_STATS_EN
    // deny counter saturation
    do_reset();
    sat_exp = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      send(0, 16'(k), 32'h0000_F000 + 32'(k * 16), 8'd0, 3'd0);
      wait_resp(0, g);
      check("t6_denied", g, 0);
      check("t6_deny_r_sat", DENY_CNT_R, sat_exp[k]);
    end
`endif

    // random traffic with occasional mid-flight resets
    for (int c = 0; c < 3000; c++) begin
      AR_VALID = ($urandom_range(0, 1) == 1);
      AW_VALID = ($urandom_range(0, 1) == 1);
      AR_ID = 16'($urandom); AW_ID = 16'($urandom);
      AR_ADDR = $urandom; AW_ADDR = $urandom;
      if ($urandom_range(0, 1) == 1) AR_ADDR[15:12] = 4'($urandom_range(14, 15));
      if ($urandom_range(0, 1) == 1) AW_ADDR[15:12] = 4'($urandom_range(14, 15));
      AR_LEN = 8'($urandom); AW_LEN = 8'($urandom);
      AR_SIZE = 3'($urandom); AW_SIZE = 3'($urandom);
      AR_RES_READY = ($urandom_range(0, 9) < 7);
      AW_RES_READY = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 399) == 0) begin
        #2 ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
      end else begin
        @(posedge ACLK); #1;
      end
    end
    AR_VALID = 1'b0; AW_VALID = 1'b0;
    @(posedge ACLK); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_check_arbiter.md
Name: pu_check_arbiter

Overview:
Shares one combinational policy-check datapath between the AXI read-address and write-address channels of the protection unit. Round-robin arbitration picks a pending request, latches its attributes, and drives them to the checker for one cycle. It registers the grant/deny verdict and returns it on a per-channel result handshake. It sits between the AR/AW slave-side request capture and the forwarding/denial logic.

Parameters:
ID_WIDTH, 16, transaction ID width, equal to the checker ID width
ADDR_WIDTH, 32, address width, equal to the checker address width
STAT_WIDTH, 16, width of the denial counters (optional feature only)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
AR_VALID  in  1  read request pending
AR_READY  out  1  read request accepted this cycle
AR_ID  in  ID_WIDTH  read request ID
AR_ADDR  in  ADDR_WIDTH  read start address
AR_LEN  in  8  read burst length (axi_pkg::len_t)
AR_SIZE  in  3  read beat size (axi_pkg::size_t)
AW_VALID, AW_READY, AW_ID, AW_ADDR, AW_LEN, AW_SIZE  same widths and directions as the AR_* ports, write request
CHK_ID  out  ID_WIDTH  to checker ID
CHK_ADDR  out  ADDR_WIDTH  to checker ADDR
CHK_LEN  out  8  to checker LEN
CHK_SIZE  out  3  to checker SIZE
CHK_READ_WRITE  out  1  to checker; 0 = read, 1 = write
CHK_GRANTED  in  1  checker verdict (combinational from CHK_*)
AR_RES_VALID  out  1  read verdict available
AR_RES_READY  in  1  read verdict consumed
AR_RES_GRANTED  out  1  read verdict; 1 = permitted
AW_RES_VALID, AW_RES_READY, AW_RES_GRANTED  same as the AR_RES_* ports, write verdict
DENY_CNT_R  out  STAT_WIDTH  denied reads (optional feature only)
DENY_CNT_W  out  STAT_WIDTH  denied writes (optional feature only)

Behaviour:
- Reset: state = IDLE; all READY, RES_VALID and RES_GRANTED outputs 0; CHK_* = 0; priority pointer = read-first; counters = 0.
- FSM states:
  - IDLE: arbitrate among pending requests. If the chosen request is valid, assert its READY combinationally (same cycle as VALID). Latch ID/ADDR/LEN/SIZE and the direction into holding registers, then go to CHECK. The non-chosen READY stays 0.
  - CHECK (exactly 1 cycle): CHK_* are driven only from the holding registers, so they are stable for the whole cycle. Sample CHK_GRANTED into a verdict register at the clock edge, then go to RESP.
  - RESP: assert RES_VALID on the latched direction only, with RES_GRANTED = the verdict register. Hold both stable until that RES_READY = 1, then go to IDLE at that edge.
- CHK_* hold their last value outside CHECK; no combinational path from AR_*/AW_* to CHK_*.
- Arbitration:
  - Round-robin between the two channels. When both are valid in IDLE, the channel not served last wins.
  - When only one is valid, it wins regardless of the pointer.
  - The pointer updates only on acceptance.
- Latency: accept at cycle N; CHECK in N+1; RES_VALID high from N+2. Peak throughput is one check per 3 cycles when RES_READY is tied high.
- No back-to-back overlap: AR_READY and AW_READY are 0 outside IDLE.
- A VALID deasserted before READY is legal; nothing is captured.
- Reset mid-operation (CHECK or RESP): the in-flight request and its verdict are discarded, there is no RES_VALID afterwards, and the FSM returns to IDLE.
- AR_READY and AW_READY are never high in the same cycle; AR_RES_VALID and AW_RES_VALID are never high in the same cycle.

Optional Feature:
PU_CHECK_DENY_STATS_EN
- Defined:
  - DENY_CNT_R / DENY_CNT_W increment by 1 at the CHECK→RESP edge when the sampled CHK_GRANTED = 0 for a read / write request.
  - Counters saturate at all-ones (no wrap) and clear only on reset.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Single read: AR_VALID=1, ADDR=0x1000, checker GRANTED=1 → AR_READY same cycle; CHK_READ_WRITE=0 and CHK_ADDR=0x1000 in cycle N+1; AR_RES_VALID=1 with GRANTED=1 at N+2; AW_RES_VALID stays 0.
2. Simultaneous AR_VALID and AW_VALID held high after reset, RES_READY=1 → service order read, write, read, write; acceptances 3 cycles apart.
3. Denied write: AW_VALID, GRANTED=0 → AW_RES_GRANTED=0. With PU_CHECK_DENY_STATS_EN, DENY_CNT_W=1 and DENY_CNT_R=0.
4. Backpressure: AR_RES_READY=0 for 5 cycles → AR_RES_VALID/GRANTED held stable; a pending AW is not accepted (AW_READY=0) until the cycle after AR_RES_READY=1.
5. Reset asserted during CHECK → outputs return to reset values asynchronously; no RES_VALID after release; the next request is served normally.
6. Saturation (STAT_WIDTH=2, feature enabled): 5 denied reads → DENY_CNT_R reads 3 after the 3rd, 4th and 5th denials.
